// File: rtl/rc4_key_search_core.sv
// rc4_key_search_core
// One RC4 key-search lane: sweeps keys from KEY_START in steps of KEY_STRIDE,
// initialises and shuffles its S-box, decrypts the message with the PRGA and
// accepts the key only if every decoded byte is a lowercase letter or a space.
//
// Ports
//   clk, reset        sole clock, synchronous active-high reset
//   start             one-cycle pulse, begins a search (honoured in IDLE/DONE)
//   stop              abort from another lane (honoured while busy)
//   s_addr/s_wdata/s_wren/s_q         single-port S RAM, 1-cycle read latency
//   rom_addr/rom_q                    encrypted message ROM, 1-cycle latency
//   dec_addr/dec_wdata/dec_wren       decoded message RAM
//   key               key under test; holds the winning key after success
//   busy/success/failure              status
//   state_dbg         current controller state encoding
//
// Handshake: start and stop are level-sampled single-cycle requests; there is
// no ready. Memory reads are issued in an RD state, the address is held for
// the following WT and LD states, and the data is captured in the LD state.
module rc4_key_search_core #(
    parameter int                     KEY_BYTES  = 3,
    parameter logic [8*KEY_BYTES-1:0] KEY_START  = '0,
    parameter logic [8*KEY_BYTES-1:0] KEY_STRIDE = 1,
    parameter logic [8*KEY_BYTES-1:0] KEY_LAST   = 24'h3FFFFF,
    parameter int                     MSG_LEN    = 32,
    localparam int                    KEY_W      = 8 * KEY_BYTES,
    localparam int                    MA_W       = $clog2(MSG_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_wdata,
    output logic             s_wren,
    input  logic [7:0]       s_q,
    output logic [MA_W-1:0]  rom_addr,
    input  logic [7:0]       rom_q,
    output logic [MA_W-1:0]  dec_addr,
    output logic [7:0]       dec_wdata,
    output logic             dec_wren,
    output logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             success,
    output logic             failure,
    output logic [4:0]       state_dbg
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,  S_INIT   = 5'd1,
        SH_RDI   = 5'd2,  SH_WTI   = 5'd3,  SH_LDI = 5'd4,  SH_RDJ = 5'd5,
        SH_WTJ   = 5'd6,  SH_LDJ   = 5'd7,  SH_WRI = 5'd8,  SH_WRJ = 5'd9,
        D_RDI    = 5'd10, D_WTI    = 5'd11, D_LDI  = 5'd12, D_RDJ  = 5'd13,
        D_WTJ    = 5'd14, D_LDJ    = 5'd15, D_WRI  = 5'd16, D_WRJ  = 5'd17,
        D_RDF    = 5'd18, D_WTF    = 5'd19, D_OUT  = 5'd20,
        S_NEXT   = 5'd21, S_DONE   = 5'd22
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [7:0]       i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [MA_W-1:0]  k_q, k_d;
    logic             success_q, success_d, failure_q, failure_d;

    logic [7:0]       key_byte;
    logic [7:0]       dec_byte;
    logic             byte_ok;
    logic [KEY_W:0]   next_key;

    // Key byte for index i, most significant byte first, cycling every KEY_BYTES.
    always_comb begin
        key_byte = key_q[8*(KEY_BYTES-1) +: 8];
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (int'(i_q) % KEY_BYTES == b) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
    end

    assign dec_byte = rom_q ^ s_q;
    assign byte_ok  = ((dec_byte >= 8'h61) && (dec_byte <= 8'h7A)) || (dec_byte == 8'h20);
    // One extra bit so a stride past the top of the key space cannot wrap.
    assign next_key = {1'b0, key_q} + {1'b0, KEY_STRIDE};

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        success_d = success_q;
        failure_d = failure_q;
        s_addr    = 8'd0;
        s_wdata   = 8'd0;
        s_wren    = 1'b0;
        rom_addr  = '0;
        dec_addr  = '0;
        dec_wdata = 8'd0;
        dec_wren  = 1'b0;
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    key_d     = KEY_START;
                    success_d = 1'b0;
                    failure_d = 1'b0;
                    i_d       = 8'd0;
                    j_d       = 8'd0;
                    k_d       = '0;
                    state_d   = S_INIT;
                end
            end
            S_INIT: begin
                s_addr  = i_q;
                s_wdata = i_q;
                s_wren  = 1'b1;
                i_d     = i_q + 8'd1;
                if (i_q == 8'd255) begin
                    j_d     = 8'd0;
                    state_d = SH_RDI;
                end
            end
            SH_RDI: begin s_addr = i_q; state_d = SH_WTI; end
            SH_WTI: begin s_addr = i_q; state_d = SH_LDI; end
            SH_LDI: begin
                s_addr  = i_q;
                si_d    = s_q;
                j_d     = j_q + s_q + key_byte;
                state_d = SH_RDJ;
            end
            SH_RDJ: begin s_addr = j_q; state_d = SH_WTJ; end
            SH_WTJ: begin s_addr = j_q; state_d = SH_LDJ; end
            SH_LDJ: begin s_addr = j_q; sj_d = s_q; state_d = SH_WRI; end
            SH_WRI: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = SH_WRJ;
            end
            SH_WRJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                i_d     = i_q + 8'd1;
                state_d = SH_RDI;
                if (i_q == 8'd255) begin
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = D_RDI;
                end
            end
            // PRGA: i is pre-incremented, so reads target i+1 until D_LDI commits it.
            D_RDI: begin s_addr = i_q + 8'd1; rom_addr = k_q; state_d = D_WTI; end
            D_WTI: begin s_addr = i_q + 8'd1; rom_addr = k_q; state_d = D_LDI; end
            D_LDI: begin
                s_addr   = i_q + 8'd1;
                rom_addr = k_q;
                si_d     = s_q;
                i_d      = i_q + 8'd1;
                j_d      = j_q + s_q;
                state_d  = D_RDJ;
            end
            D_RDJ: begin s_addr = j_q; rom_addr = k_q; state_d = D_WTJ; end
            D_WTJ: begin s_addr = j_q; rom_addr = k_q; state_d = D_LDJ; end
            D_LDJ: begin s_addr = j_q; rom_addr = k_q; sj_d = s_q; state_d = D_WRI; end
            D_WRI: begin
                s_addr   = i_q;
                s_wdata  = sj_q;
                s_wren   = 1'b1;
                rom_addr = k_q;
                state_d  = D_WRJ;
            end
            D_WRJ: begin
                s_addr   = j_q;
                s_wdata  = si_q;
                s_wren   = 1'b1;
                rom_addr = k_q;
                state_d  = D_RDF;
            end
            // si+sj is unchanged by the swap, so the pre-swap copies index the keystream.
            D_RDF: begin s_addr = si_q + sj_q; rom_addr = k_q; state_d = D_WTF; end
            D_WTF: begin s_addr = si_q + sj_q; rom_addr = k_q; state_d = D_OUT; end
            D_OUT: begin
                s_addr    = si_q + sj_q;
                rom_addr  = k_q;
                dec_addr  = k_q;
                dec_wdata = dec_byte;
                dec_wren  = 1'b1;
                if (!byte_ok) begin
                    state_d = S_NEXT;
                end else if (k_q == MA_W'(MSG_LEN - 1)) begin
                    success_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    k_d     = k_q + MA_W'(1);
                    state_d = D_RDI;
                end
            end
            S_NEXT: begin
                if (next_key > {1'b0, KEY_LAST}) begin
                    failure_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    key_d   = next_key[KEY_W-1:0];
                    i_d     = 8'd0;
                    state_d = S_INIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything the current state wanted to do.
        if (busy && stop) begin
            state_d   = S_DONE;
            key_d     = key_q;
            success_d = 1'b0;
            failure_d = 1'b0;
            s_wren    = 1'b0;
            dec_wren  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            key_q     <= KEY_START;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            k_q       <= '0;
            si_q      <= 8'd0;
            sj_q      <= 8'd0;
            success_q <= 1'b0;
            failure_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            success_q <= success_d;
            failure_q <= failure_d;
        end
    end

    assign key       = key_q;
    assign success   = success_q;
    assign failure   = failure_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rc4_key_search_core.sv
module tb_rc4_key_search_core;

  localparam int MSG_LEN = 32;
  localparam logic [4:0] ST_SH_RDJ = 5'd5;
  localparam logic [4:0] ST_SH_WRI = 5'd8;
  localparam logic [4:0] ST_D_WRI  = 5'd16;
  localparam logic [4:0] ST_DONE   = 5'd22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // lane 0: key found / abort / reset, lane 1: exhaustion, lane 2: stride
  logic        start_l   [3];
  logic        stop_l    [3];
  logic [7:0]  s_addr_l  [3];
  logic [7:0]  s_wdata_l [3];
  logic        s_wren_l  [3];
  logic [7:0]  s_q_l     [3];
  logic [4:0]  rom_addr_l[3];
  logic [7:0]  rom_q_l   [3];
  logic [4:0]  dec_addr_l[3];
  logic [7:0]  dec_wdata_l[3];
  logic        dec_wren_l[3];
  logic [23:0] key_l     [3];
  logic        busy_l    [3];
  logic        success_l [3];
  logic        failure_l [3];
  logic [4:0]  dbg_l     [3];

  rc4_key_search_core #(.KEY_BYTES(3), .KEY_START(24'h000247), .KEY_STRIDE(24'd1),
                        .KEY_LAST(24'h00024F), .MSG_LEN(MSG_LEN)) u_lane_a (
    .clk(clk), .reset(reset), .start(start_l[0]), .stop(stop_l[0]),
    .s_addr(s_addr_l[0]), .s_wdata(s_wdata_l[0]), .s_wren(s_wren_l[0]), .s_q(s_q_l[0]),
    .rom_addr(rom_addr_l[0]), .rom_q(rom_q_l[0]),
    .dec_addr(dec_addr_l[0]), .dec_wdata(dec_wdata_l[0]), .dec_wren(dec_wren_l[0]),
    .key(key_l[0]), .busy(busy_l[0]), .success(success_l[0]), .failure(failure_l[0]),
    .state_dbg(dbg_l[0]));

  rc4_key_search_core #(.KEY_BYTES(3), .KEY_START(24'h000250), .KEY_STRIDE(24'd1),
                        .KEY_LAST(24'h000252), .MSG_LEN(MSG_LEN)) u_lane_b (
    .clk(clk), .reset(reset), .start(start_l[1]), .stop(stop_l[1]),
    .s_addr(s_addr_l[1]), .s_wdata(s_wdata_l[1]), .s_wren(s_wren_l[1]), .s_q(s_q_l[1]),
    .rom_addr(rom_addr_l[1]), .rom_q(rom_q_l[1]),
    .dec_addr(dec_addr_l[1]), .dec_wdata(dec_wdata_l[1]), .dec_wren(dec_wren_l[1]),
    .key(key_l[1]), .busy(busy_l[1]), .success(success_l[1]), .failure(failure_l[1]),
    .state_dbg(dbg_l[1]));

  rc4_key_search_core #(.KEY_BYTES(3), .KEY_START(24'h000245), .KEY_STRIDE(24'd2),
                        .KEY_LAST(24'h00024F), .MSG_LEN(MSG_LEN)) u_lane_c (
    .clk(clk), .reset(reset), .start(start_l[2]), .stop(stop_l[2]),
    .s_addr(s_addr_l[2]), .s_wdata(s_wdata_l[2]), .s_wren(s_wren_l[2]), .s_q(s_q_l[2]),
    .rom_addr(rom_addr_l[2]), .rom_q(rom_q_l[2]),
    .dec_addr(dec_addr_l[2]), .dec_wdata(dec_wdata_l[2]), .dec_wren(dec_wren_l[2]),
    .key(key_l[2]), .busy(busy_l[2]), .success(success_l[2]), .failure(failure_l[2]),
    .state_dbg(dbg_l[2]));

  // ---------------- memories (1-cycle read latency) ----------------
  logic [7:0] s_mem   [3][256];
  logic [7:0] dec_mem [3][MSG_LEN];
  logic [7:0] rom_mem [MSG_LEN];
  logic       clr_dec;

  always @(posedge clk) begin
    for (int ln = 0; ln < 3; ln++) begin
      if (s_wren_l[ln]) s_mem[ln][s_addr_l[ln]] <= s_wdata_l[ln];
      s_q_l[ln]   <= s_mem[ln][s_addr_l[ln]];
      rom_q_l[ln] <= rom_mem[rom_addr_l[ln]];
      if (clr_dec) begin
        for (int n = 0; n < MSG_LEN; n++) dec_mem[ln][n] <= 8'h00;
      end else if (dec_wren_l[ln]) begin
        dec_mem[ln][dec_addr_l[ln]] <= dec_wdata_l[ln];
      end
    end
  end

  // ---------------- monitors ----------------
  logic [7:0]  jtr[$];   // lane 0 j values seen in SH_RDJ, first attempt
  logic [23:0] ktr[$];   // lane 2 distinct keys while busy

  always @(negedge clk) begin
    if (dbg_l[0] == ST_SH_RDJ && jtr.size() < 256) jtr.push_back(s_addr_l[0]);
    if (busy_l[2] && (ktr.size() == 0 || ktr[$] != key_l[2])) ktr.push_back(key_l[2]);
  end

  // ---------------- reference model ----------------
  logic [7:0] ks_m   [MSG_LEN];
  logic [7:0] jseq_m [256];
  logic [7:0] pt     [MSG_LEN];

  task automatic rc4_gen(input logic [23:0] k);
    logic [7:0] s[256];
    logic [7:0] i, j, t, kb;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      kb = k[8*(2-(n%3)) +: 8];
      j = j + s[n] + kb;
      jseq_m[n] = j;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 8'd0; j = 8'd0;
    for (int n = 0; n < MSG_LEN; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      ks_m[n] = s[t];
    end
  endtask

  // Cycles a rejected key costs, including its NEXT_KEY cycle.
  task automatic reject_cost(input logic [23:0] k, output int cost);
    int bad;
    logic [7:0] b;
    rc4_gen(k);
    bad = MSG_LEN - 1;
    for (int n = MSG_LEN - 1; n >= 0; n--) begin
      b = rom_mem[n] ^ ks_m[n];
      if (!((b >= 8'h61 && b <= 8'h7A) || b == 8'h20)) bad = n;
    end
    cost = 256 + 2048 + 11 * (bad + 1) + 1;
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_lane(input int ln);
    @(negedge clk);
    start_l[ln] = 1'b1;
    @(posedge clk);
    #1;
    start_l[ln] = 1'b0;
  endtask

  // cyc counts the start cycle plus every busy cycle after the start edge.
  task automatic wait_done(input int ln, input int cyc0, input int budget, output int cyc);
    bit fin;
    fin = 1'b0;
    cyc = cyc0;
    while (!fin && cyc <= budget) begin
      @(negedge clk);
      if (!busy_l[ln]) fin = 1'b1;
      else cyc++;
    end
    check("done_within_budget", 32'(fin), 32'd1);
  endtask

  task automatic pulse_clr_dec();
    @(negedge clk);
    clr_dec = 1'b1;
    @(negedge clk);
    clr_dec = 1'b0;
  endtask

  task automatic check_dec(input int ln, input string tag);
    for (int n = 0; n < MSG_LEN; n++) check(tag, 32'(dec_mem[ln][n]), 32'(pt[n]));
  endtask

  // Hard stop in case something never returns.
  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    string pt_s;
    int c247, c248, c250, c251, c252, c245, cyc, wr_cnt;
    bit found;

    reset = 1'b1;
    clr_dec = 1'b0;
    for (int ln = 0; ln < 3; ln++) begin start_l[ln] = 1'b0; stop_l[ln] = 1'b0; end

    pt_s = "the quick brown fox jumps over x";
    for (int n = 0; n < MSG_LEN; n++) pt[n] = pt_s[n];
    rc4_gen(24'h000249);
    for (int n = 0; n < MSG_LEN; n++) rom_mem[n] = pt[n] ^ ks_m[n];
    reject_cost(24'h000245, c245);
    reject_cost(24'h000248, c248);
    reject_cost(24'h000250, c250);
    reject_cost(24'h000251, c251);
    reject_cost(24'h000252, c252);
    reject_cost(24'h000247, c247);   // leaves jseq_m for key 000247

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    check("rst_busy",     32'(busy_l[0]),    32'd0);
    check("rst_success",  32'(success_l[0]), 32'd0);
    check("rst_failure",  32'(failure_l[0]), 32'd0);
    check("rst_s_wren",   32'(s_wren_l[0]),  32'd0);
    check("rst_dec_wren", 32'(dec_wren_l[0]), 32'd0);
    check("rst_s_addr",   32'(s_addr_l[0]),  32'd0);
    check("rst_key_a",    32'(key_l[0]),     32'h000247);
    check("rst_key_b",    32'(key_l[1]),     32'h000250);

    // key found, with INIT sweep checked cycle by cycle
    pulse_clr_dec();
    start_lane(0);
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      check("init_write", {15'd0, s_wren_l[0], s_addr_l[0], s_wdata_l[0]}, {15'd0, 1'b1, 8'(n), 8'(n)});
    end
    wait_done(0, 257, 20000, cyc);
    check("found_cycles",  32'(cyc), 32'(c247 + c248 + 2657));
    check("found_success", 32'(success_l[0]), 32'd1);
    check("found_failure", 32'(failure_l[0]), 32'd0);
    check("found_key",     32'(key_l[0]), 32'h000249);
    check_dec(0, "found_dec");
    check("jtrace_len", 32'(jtr.size()), 32'd256);
    for (int n = 0; n < 256 && n < jtr.size(); n++) check("jtrace", 32'(jtr[n]), 32'(jseq_m[n]));

    // abort during the shuffle of attempt 3
    start_lane(0);
    found = 1'b0;
    for (int n = 0; n < 20000 && !found; n++) begin
      @(negedge clk);
      if (key_l[0] == 24'h000249 && dbg_l[0] == ST_SH_WRI) found = 1'b1;
    end
    check("abort_reached", 32'(found), 32'd1);
    stop_l[0] = 1'b1;
    #1;
    check("abort_wr_suppressed", 32'(s_wren_l[0]), 32'd0);
    @(posedge clk);
    #1;
    stop_l[0] = 1'b0;
    check("abort_state",   32'(dbg_l[0]), 32'(ST_DONE));
    check("abort_busy",    32'(busy_l[0]), 32'd0);
    check("abort_success", 32'(success_l[0]), 32'd0);
    check("abort_failure", 32'(failure_l[0]), 32'd0);
    wr_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_wren_l[0] || dec_wren_l[0]) wr_cnt++;
    end
    check("abort_no_writes", 32'(wr_cnt), 32'd0);

    // reset during D_WRI, then a clean rerun
    start_lane(0);
    found = 1'b0;
    for (int n = 0; n < 5000 && !found; n++) begin
      @(negedge clk);
      if (dbg_l[0] == ST_D_WRI) found = 1'b1;
    end
    check("dwri_reached", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mrst_s_wren",    32'(s_wren_l[0]),    32'd0);
    check("mrst_dec_wren",  32'(dec_wren_l[0]),  32'd0);
    check("mrst_s_addr",    32'(s_addr_l[0]),    32'd0);
    check("mrst_s_wdata",   32'(s_wdata_l[0]),   32'd0);
    check("mrst_rom_addr",  32'(rom_addr_l[0]),  32'd0);
    check("mrst_dec_addr",  32'(dec_addr_l[0]),  32'd0);
    check("mrst_dec_wdata", 32'(dec_wdata_l[0]), 32'd0);
    check("mrst_key",       32'(key_l[0]),       32'h000247);
    check("mrst_busy",      32'(busy_l[0]),      32'd0);
    check("mrst_success",   32'(success_l[0]),   32'd0);
    check("mrst_failure",   32'(failure_l[0]),   32'd0);
    pulse_clr_dec();
    start_lane(0);
    wait_done(0, 1, 20000, cyc);
    check("rerun_cycles",  32'(cyc), 32'(c247 + c248 + 2657));
    check("rerun_success", 32'(success_l[0]), 32'd1);
    check("rerun_key",     32'(key_l[0]), 32'h000249);
    check_dec(0, "rerun_dec");

    // exhaustion
    start_lane(1);
    wait_done(1, 1, 20000, cyc);
    check("exh_cycles",  32'(cyc), 32'(1 + c250 + c251 + c252));
    check("exh_failure", 32'(failure_l[1]), 32'd1);
    check("exh_success", 32'(success_l[1]), 32'd0);
    check("exh_key",     32'(key_l[1]), 32'h000252);

    // stride partition: odd keys only
    start_lane(2);
    wait_done(2, 1, 20000, cyc);
    check("stride_cycles",  32'(cyc), 32'(c245 + c247 + 2657));
    check("stride_success", 32'(success_l[2]), 32'd1);
    check("stride_key",     32'(key_l[2]), 32'h000249);
    check("stride_keys_len", 32'(ktr.size()), 32'd3);
    if (ktr.size() == 3) begin
      check("stride_key0", 32'(ktr[0]), 32'h000245);
      check("stride_key1", 32'(ktr[1]), 32'h000247);
      check("stride_key2", 32'(ktr[2]), 32'h000249);
    end
    check_dec(2, "stride_dec");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
